// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode set, control FSM states and the Z/N/C/V flag bundle.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_XOR    = 4'd1,
    OP_SUB    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_SHL    = 4'd5,
    OP_SHR    = 4'd6,
    OP_PASS_B = 4'd7,
    OP_MUL    = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage : alu_seq_pkg

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the register-read stage, the ALU and writeback.
// master = upstream issuer plus result consumer; slave = the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] alu_in_a;
  logic [WIDTH-1:0] alu_in_b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero_flag;
  logic             negative_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic             illegal_op;
  logic             busy;

  modport master (
    output in_valid, op_sel, alu_in_a, alu_in_b, out_ready,
    input  in_ready, out_valid, alu_result, zero_flag, negative_flag,
           carry_flag, overflow_flag, illegal_op, busy
  );

  modport slave (
    input  in_valid, op_sel, alu_in_a, alu_in_b, out_ready,
    output in_ready, out_valid, alu_result, zero_flag, negative_flag,
           carry_flag, overflow_flag, illegal_op, busy
  );

endinterface : alu_seq_if

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps per product.
// prod_o presents the accumulator after the current step, so it is the full product while done_o is high.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     hi_sum;
  logic [CW-1:0]      cnt_q;
  logic               run_q;

  // Multiplier sits in the low half and is consumed LSB-first as the accumulator shifts right.
  always_comb begin
    hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d  = {hi_sum, acc_q[WIDTH-1:1]};
  end

  assign done_o = run_q && (cnt_q == '0);
  assign prod_o = acc_d;

  // NOTE: the datapath registers are reset as well; there are only a few and it keeps X out of the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
      cnt_q   <= CW'(WIDTH - 1);
      run_q   <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule : alu_mul_iter

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready in and out, registered result and Z/N/C/V flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (op 8); otherwise op 8 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  alu_flags_t       alu_flags;

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (bus.alu_in_a),
    .b_i     (bus.alu_in_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`endif

  assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Both differences are taken one bit wider so the top bit is the carry-out / borrow.
  assign add_full = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b};
  assign sub_full = {1'b0, bus.alu_in_a} - {1'b0, bus.alu_in_b};
  assign shamt    = bus.alu_in_b[SHW-1:0];

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.op_sel)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (bus.alu_in_a[WIDTH-1] == bus.alu_in_b[WIDTH-1]) &&
                  (add_full[WIDTH-1] != bus.alu_in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (bus.alu_in_a[WIDTH-1] != bus.alu_in_b[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != bus.alu_in_a[WIDTH-1]);
      end
      OP_XOR:    alu_res = bus.alu_in_a ^ bus.alu_in_b;
      OP_AND:    alu_res = bus.alu_in_a & bus.alu_in_b;
      OP_OR:     alu_res = bus.alu_in_a | bus.alu_in_b;
      OP_SHL:    alu_res = bus.alu_in_a << shamt;
      OP_SHR:    alu_res = bus.alu_in_a >> shamt;
      OP_PASS_B: alu_res = bus.alu_in_b;
      default:   alu_ill = 1'b1;
    endcase
    alu_flags = '{z: (alu_res == '0), n: alu_res[WIDTH-1], c: alu_c, v: alu_v};
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      // DONE with out_ready behaves like IDLE: the held result leaves as the next op enters.
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.op_sel == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else
`endif
          begin
            result_d  = alu_res;
            flags_d   = alu_flags;
            illegal_d = alu_ill;
            state_d   = ST_DONE;
          end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          result_d  = mul_prod[WIDTH-1:0];
          flags_d   = '{z: (mul_prod[WIDTH-1:0] == '0),
                        n: mul_prod[WIDTH-1],
                        c: |mul_prod[2*WIDTH-1:WIDTH],
                        v: |mul_prod[2*WIDTH-1:WIDTH]};
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid     = (state_q == ST_DONE);
  assign bus.alu_result    = result_q;
  assign bus.zero_flag     = flags_q.z;
  assign bus.negative_flag = flags_q.n;
  assign bus.carry_flag    = flags_q.c;
  assign bus.overflow_flag = flags_q.v;
  assign bus.illegal_op    = illegal_q;
`ifdef ALU_SEQ_MUL_EN
  assign bus.busy          = (state_q == ST_MUL);
`else
  assign bus.busy          = 1'b0;
`endif

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model with an expected-result queue,
// a per-cycle output compare process, and directed vectors with hand-computed expectations.
module tb_alu_seq;

  localparam int     W      = 16;
  localparam longint TWO_W  = 64'sd1 << W;
  localparam longint MAX_S  = (64'sd1 << (W - 1)) - 1;
  localparam longint MIN_S  = -(64'sd1 << (W - 1));

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         ill;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural definition of each op.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      ua, ub, sa, sb, r;
    logic [63:0] rr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    e  = '0;
    case (op)
      4'd0: begin
        r   = ua + ub;
        e.c = (r >= TWO_W);
        e.v = ((sa + sb) > MAX_S) || ((sa + sb) < MIN_S);
      end
      4'd1: r = ua ^ ub;
      4'd2: begin
        r   = ua - ub;
        e.c = (ua < ub);
        e.v = ((sa - sb) > MAX_S) || ((sa - sb) < MIN_S);
      end
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua << (ub % W);
      4'd6: r = ua >> (ub % W);
      4'd7: r = ub;
`ifdef ALU_SEQ_MUL_EN
      4'd8: begin
        r   = ua * ub;
        e.c = (r >= TWO_W);
        e.v = (r >= TWO_W);
      end
`endif
      default: e.ill = 1'b1;
    endcase
    rr    = r;
    e.res = e.ill ? '0 : rr[W-1:0];
    e.z   = (e.res == '0);
    e.n   = (longint'(e.res) > MAX_S);
    return e;
  endfunction

  // Handshake tracker: push on accept, pop on consume; reset discards anything in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op_sel, bus.alu_in_a, bus.alu_in_b));
    end
  end

  // Compare process: whenever a result is presented it must equal the oldest outstanding one.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        check("model_result",
              64'({bus.alu_result, bus.zero_flag, bus.negative_flag,
                   bus.carry_flag, bus.overflow_flag, bus.illegal_op}),
              64'(exp_q[0]));
      end
    end
  end

  // Present one op, hold it until accepted (bounded), then drop in_valid one tick after the edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited;
    bus.op_sel   = op;
    bus.alu_in_a = a;
    bus.alu_in_b = b;
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [W-1:0] res,
                           input logic z, input logic n, input logic c, input logic v, input logic ill);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check(name, 64'({bus.alu_result, bus.zero_flag, bus.negative_flag,
                     bus.carry_flag, bus.overflow_flag, bus.illegal_op}),
          64'({res, z, n, c, v, ill}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b2b_a[5];
    logic [W-1:0] b2b_b[5];
    logic [3:0]   b2b_op[5];
    logic [W-1:0] b2b_lit[5];
    vec_t         vecs[9];
    int           hits;

    b2b_op  = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
    b2b_a   = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h0001, 16'h8000};
    b2b_b   = '{16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h000F, 16'h0010};
    b2b_lit = '{16'h0FF0, 16'h000F, 16'h0FFF, 16'h8000, 16'h8000};

    vecs = '{'{4'd0, 16'h7FFF, 16'h0001},
             '{4'd2, 16'h0000, 16'h0001},
             '{4'd2, 16'h8000, 16'h7FFF},
             '{4'd5, 16'h8001, 16'h0001},
             '{4'd6, 16'hF0F0, 16'h0024},
             '{4'd7, 16'h1234, 16'hBEEF},
             '{4'd8, 16'h0123, 16'h0045},
             '{4'd15, 16'hAAAA, 16'h5555},
             '{4'd0, 16'h8000, 16'h8000}};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_sel   = 4'd0;
    bus.alu_in_a = '0;
    bus.alu_in_b = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_outputs", 64'({bus.alu_result, bus.zero_flag, bus.negative_flag,
                              bus.carry_flag, bus.overflow_flag, bus.illegal_op}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry out of the top bit, zero result.
    send(4'd0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    check_out("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    send(4'd2, 16'h8000, 16'h0001);
    @(negedge clk);
    check_out("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send(4'd2, 16'h0003, 16'h0005);
    @(negedge clk);
    check_out("sub_borrow", 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back stream: one accept and one result per cycle.
    for (int i = 0; i < 5; i++) begin
      bus.op_sel   = b2b_op[i];
      bus.alu_in_a = b2b_a[i];
      bus.alu_in_b = b2b_b[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      if (i > 0) check("b2b_result", 64'(bus.alu_result), 64'(b2b_lit[i-1]));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_result", 64'(bus.alu_result), 64'(b2b_lit[4]));
    @(posedge clk);
    #1;

    // Multiply: 0x0100 * 0x0100 overflows the low half entirely.
    send(4'd8, 16'h0100, 16'h0100);
`ifdef ALU_SEQ_MUL_EN
    begin
      int lat;
      int busy_cnt;
      int ready_cnt;
      lat = 0;
      busy_cnt = 0;
      ready_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          lat = k;
          break;
        end
        if (bus.busy) busy_cnt++;
        if (bus.in_ready) ready_cnt++;
      end
      check("mul_latency", 64'(lat), 64'd17);
      check("mul_busy_cycles", 64'(busy_cnt), 64'd16);
      check("mul_in_ready_low", 64'(ready_cnt), 64'd0);
      check_out("mul_result", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
`else
    @(negedge clk);
    check_out("mul_disabled", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mul_disabled_busy", 64'(bus.busy), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Backpressure in DONE: result holds, next op waits, then both move on one edge.
    bus.out_ready = 1'b0;
    send(4'd0, 16'h1234, 16'h0001);
    bus.op_sel   = 4'd4;
    bus.alu_in_a = 16'h00F0;
    bus.alu_in_b = 16'h000F;
    bus.in_valid = 1'b1;
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.in_ready || !bus.out_valid || bus.alu_result !== 16'h1235) hits++;
      bus.alu_in_a = (k == 4) ? 16'h00F0 : 16'h00F0;
      @(posedge clk);
      #1;
    end
    check("stall_hold", 64'(hits), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("stall_next", 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset while a result is held drops it.
    bus.out_ready = 1'b0;
    send(4'd7, 16'h0000, 16'h5A5A);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done_result", 64'(bus.alu_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

`ifdef ALU_SEQ_MUL_EN
    // Reset mid-multiply: nothing must ever come out.
    send(4'd8, 16'h00FF, 16'h00FF);
    repeat (8) @(negedge clk);
    check("mid_mul_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_mul_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy || !bus.in_ready) hits++;
    end
    check("mid_mul_aborted", 64'(hits), 64'd0);
    @(posedge clk);
    #1;
`endif

    // Illegal opcode.
    send(4'd12, 16'h1234, 16'h5678);
    @(negedge clk);
    check_out("illegal_12", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Model-checked directed vectors, issued back to back.
    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b);
    repeat (W + 4) @(posedge clk);
    #1;

    check("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_seq

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential successor to the team's combinational 16-bit ALU. It accepts one operation at a time over a valid/ready handshake and returns a registered result with a four-bit flag set (Z/N/C/V). It adds shifts, OR/AND and an optional iterative multiplier. The block sits between the decode/register-read stage and writeback, and its backpressure stalls the core.

## Interface
- WIDTH, 16, datapath width in bits; legal values are powers of two, 8 to 64.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation can be accepted this cycle
- op_sel  in  4  opcode: 0 ADD, 1 XOR, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 SHR (logical), 7 PASS_B, 8 MUL; 9–15 illegal
- alu_in_a, alu_in_b  in  WIDTH  operands; shifts use alu_in_b[SHW-1:0]
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- alu_result  out  WIDTH  registered result
- zero_flag, negative_flag, carry_flag, overflow_flag  out  1  registered flags
- illegal_op  out  1  registered; 1 when the held result came from an illegal opcode
- busy  out  1  multiply in progress

## Operation
- FSM states are IDLE, MUL and DONE. Reset enters IDLE.
- Accept condition: in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives throughput of one op per cycle when out_ready is held high.
- Accept of a non-MUL op:
  - Result and flags are computed combinationally and registered at the accepting edge.
  - Next state is DONE.
- Accept of MUL:
  - Operands are latched and the iteration counter is set to WIDTH-1.
  - Next state is MUL.
  - One shift-add step runs per cycle for WIDTH cycles, then the FSM goes to DONE with the low WIDTH product bits.
- In DONE, out_valid=1 and outputs hold stable until out_ready.
  - out_ready & !in_valid → IDLE.
  - out_ready & accept → the new op is processed as if accepted from IDLE.
- Flags:
  - zero_flag = (alu_result==0).
  - negative_flag = alu_result[WIDTH-1].
  - ADD: C = carry-out of the WIDTH+1-bit sum; V = signed overflow.
  - SUB: C = borrow (1 iff a<b unsigned); V = signed overflow.
  - MUL: C = V = (high WIDTH product bits != 0).
  - All other ops: C = V = 0.
- Shifts: amount 0 passes A through unchanged; bits shifted out are discarded, and C=0.
- Illegal opcode: result 0, Z=1, N=C=V=0, illegal_op=1, latency 1. For every legal op, illegal_op=0.
- in_valid while busy is ignored: in_ready=0, and the upstream stage must hold its inputs.

## Timing
- Reset values: alu_result=0, all flags 0, illegal_op=0, out_valid=0, busy=0, state IDLE. in_ready reads 1 while in reset.
- Non-MUL latency: accept at edge N gives out_valid high from edge N onward, i.e. visible in cycle N+1.
- MUL latency: WIDTH+1 cycles from accept to out_valid. busy is high exactly WIDTH cycles.
- Reset asserted mid-MUL aborts the operation. No out_valid is produced and the partial product is discarded.
- Operands are sampled only on accept. Changing alu_in_a or alu_in_b during MUL or DONE has no effect.
- The result is dropped only on out_valid & out_ready. No result is ever lost or duplicated.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - MUL state, counter and the alu_mul_iter instance are compiled in.
  - op 8 multiplies as described above.
- ALU_SEQ_MUL_EN undefined:
  - The MUL path is removed.
  - op 8 behaves as illegal (result 0, illegal_op=1, latency 1).
  - busy is tied to 0.

## Structure
- Package alu_seq_pkg holds:
  - the opcode enum alu_op_e (4-bit) with the values listed above;
  - the FSM enum alu_state_e;
  - a flags struct {z,n,c,v}.
- Sub-module alu_mul_iter is the shift-add datapath. It holds the WIDTH-bit multiplicand, a 2·WIDTH-bit accumulator and the step counter, with start/done ports. It is instantiated only under ALU_SEQ_MUL_EN.

## Test plan
- Reset, then ADD 0xFFFF+0x0001 with WIDTH=16 and out_ready=1 → one cycle later result 0x0000, Z=1, C=1, V=0, N=0.
- SUB 0x8000−0x0001 → result 0x7FFF, V=1, C=0, N=0. Then SUB 0x0003−0x0005 → result 0xFFFE, C=1, N=1.
- Back-to-back XOR, AND, OR, SHL(0x0001, 15), SHR(0x8000, 0) with out_ready=1 → results 1 per cycle: expected XOR/AND/OR values, then 0x8000, then 0x8000.
- MUL 0x0100×0x0100 → out_valid exactly 17 cycles after accept, result 0x0000, C=V=1, Z=1. in_ready=0 and busy=1 for 16 cycles.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 → outputs stable, in_ready=0, no accept. Then out_ready=1 → result consumed and the next op accepted in the same cycle.
- Assert rst_n=0 at cycle 8 of a MUL → out_valid never rises, state IDLE, in_ready=1. Opcode 12 → result 0, illegal_op=1, Z=1.
